data_mem_responder: RTL

- Data-memory responder for the multicycle LEGv8 core; the memory-side end of the control word's mem_read/mem_write/size fields.
- Accepts one load or store from the control/datapath, performs it after a fixed latency, returns read data with a one-cycle ready pulse.
- Flags misaligned, out-of-range or conflicting requests.
- Sits between datapath address/B-bus and the register-file write-back mux.

---
 rtl/data_mem_responder.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_responder
// Description : Data-memory responder for the multicycle LEGv8 core. Accepts
//               one load or store, performs it after a fixed latency, and
//               returns zero-extended read data with a one-cycle ready pulse.
//               Misaligned, out-of-range and read/write-conflict requests
//               complete with error set and leave all state untouched.
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  size,
    input  logic [63:0] address,
    input  logic [63:0] wdata,
    output logic [63:0] rdata,
    output logic        ready,
    output logic        error
);

    localparam int          c_IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [64:0] c_LIMIT    = 65'(8 * DEPTH_WORDS);
    localparam logic [3:0]  c_CNT_INIT = 4'(LATENCY - 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_BUSY    = 2'd1;
    localparam logic [1:0] S_DONE    = 2'd2;
    localparam logic [1:0] S_RELEASE = 2'd3;

    logic [1:0]  r_state;
    logic [3:0]  r_cnt;
    logic [63:0] r_addr;
    logic [1:0]  r_size;
    logic [63:0] r_wdata;
    logic        r_rd;
    logic        r_wr;
    logic [63:0] r_rdata;
    logic        r_ready;
    logic        r_error;
    logic [63:0] r_mem [DEPTH_WORDS];

    logic               w_start;
    logic               w_live;
    logic               w_op_rd;
    logic               w_op_wr;
    logic [1:0]         w_op_size;
    logic [63:0]        w_op_addr;
    logic [63:0]        w_op_wdata;
    logic               w_access;
    logic [3:0]         w_nbytes;
    logic               w_misalign;
    logic [64:0]        w_end;
    logic               w_oor;
    logic               w_fault;
    logic [c_IDX_W-1:0] w_idx;
    logic [63:0]        w_word;
    logic [5:0]         w_shamt;
    logic [63:0]        w_szmask;
    logic [63:0]        w_bmask;
    logic [63:0]        w_load;
    logic [63:0]        w_merged;
    logic               w_mem_we;

    // Operand selection and fault/data-path computation for the access being performed.
    // With LATENCY=1 the access happens on the accept edge, so live inputs are used then.
    always_comb begin
        w_start    = (r_state == S_IDLE) && (mem_read || mem_write);
        w_live     = (r_state == S_IDLE);
        w_op_rd    = w_live ? mem_read  : r_rd;
        w_op_wr    = w_live ? mem_write : r_wr;
        w_op_size  = w_live ? size      : r_size;
        w_op_addr  = w_live ? address   : r_addr;
        w_op_wdata = w_live ? wdata     : r_wdata;
        w_access   = (w_start && (LATENCY == 1)) || ((r_state == S_BUSY) && (r_cnt == 4'd0));

        w_nbytes   = 4'd1 << w_op_size;
        // For 8 bytes the low three bits wrap to 0 and minus one gives mask 3'b111.
        w_misalign = (w_op_addr[2:0] & (w_nbytes[2:0] - 3'd1)) != 3'd0;
        // 65-bit sum so a wrap past 2^64 is caught as out of range.
        w_end      = {1'b0, w_op_addr} + {61'd0, w_nbytes} - 65'd1;
        w_oor      = (w_end >= c_LIMIT);
        w_fault    = w_misalign || w_oor || (w_op_rd && w_op_wr);

        w_idx      = w_op_addr[3 +: c_IDX_W];
        w_word     = r_mem[w_idx];
        w_shamt    = {w_op_addr[2:0], 3'b000};
        case (w_op_size)
            2'b00:   w_szmask = 64'h0000_0000_0000_00FF;
            2'b01:   w_szmask = 64'h0000_0000_0000_FFFF;
            2'b10:   w_szmask = 64'h0000_0000_FFFF_FFFF;
            default: w_szmask = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
        w_load     = (w_word >> w_shamt) & w_szmask;
        w_bmask    = w_szmask << w_shamt;
        w_merged   = (w_word & ~w_bmask) | ((w_op_wdata << w_shamt) & w_bmask);
        // Gated by reset so an abandoned request can never land in the array.
        w_mem_we   = reset && w_access && !w_fault && w_op_wr;
    end

    // Storage array: read-modify-write of the indexed word; contents survive reset.
    always_ff @(posedge clock) begin
        if (w_mem_we) begin
            r_mem[w_idx] <= w_merged;
        end
    end

    // Request handshake FSM with registered completion outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_addr  <= 64'd0;
            r_size  <= 2'd0;
            r_wdata <= 64'd0;
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            r_rdata <= 64'd0;
            r_ready <= 1'b0;
            r_error <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_addr  <= address;
                        r_size  <= size;
                        r_wdata <= wdata;
                        r_rd    <= mem_read;
                        r_wr    <= mem_write;
                        r_cnt   <= c_CNT_INIT;
                        r_state <= (LATENCY == 1) ? S_DONE : S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_DONE: begin
                    r_ready <= 1'b0;
                    r_error <= 1'b0;
                    r_state <= S_RELEASE;
                end
                default: begin
                    if (!mem_read && !mem_write) begin
                        r_state <= S_IDLE;
                    end
                end
            endcase

            if (w_access) begin
                r_ready <= 1'b1;
                r_error <= w_fault;
                if (!w_fault && w_op_rd) begin
                    r_rdata <= w_load;
                end
            end
        end
    end

    assign rdata = r_rdata;
    assign ready = r_ready;
    assign error = r_error;

endmodule
`default_nettype wire
